prdec_seq: RTL and testbench

Sequential 2-to-4 priority-code decoder: the receiving end of the 4-line priority encoder's {A, B, Y} output. Accepts encoded codes through a valid/ready handshake and buffers them in a small FIFO. Each code is replayed as a one-hot pulse on D0..D3, held for a fixed number of cycles. Sits downstream of `prenc` to regenerate the request line, or to drive line-select logic from a code stream.

---
 rtl/prdec_pkg.sv | 35 +++
 rtl/prdec_fifo.sv | 51 +++++
 rtl/prdec_seq.sv | 131 +++++++++++++
 tb/tb_prdec_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/prdec_pkg.sv
// prdec_pkg: shared constants, FSM state type and code decode helper for
// the sequential 2-to-4 priority-code decoder (prdec_seq).
package prdec_pkg;

    // Stored code layout: {Y, A, B}
    localparam int CODE_W    = 3;
    localparam int CODE_Y    = 2;
    localparam int CODE_A    = 1;
    localparam int CODE_B    = 0;

    // Decoded line indices
    localparam int LINE_0    = 0;
    localparam int LINE_1    = 1;
    localparam int LINE_2    = 2;
    localparam int LINE_3    = 3;
    localparam int NUM_LINES = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_e;

    // One-hot decode of a stored code; Y=0 yields an all-zero slot.
    function automatic logic [NUM_LINES-1:0] decode_code(input logic [CODE_W-1:0] code);
        logic [NUM_LINES-1:0] v;
        v = {NUM_LINES{1'b0}};
        if (code[CODE_Y]) begin
            v[{code[CODE_A], code[CODE_B]}] = 1'b1;
        end else begin
            v = {NUM_LINES{1'b0}};
        end
        return v;
    endfunction

endpackage

// File: rtl/prdec_fifo.sv
// prdec_fifo: synchronous FIFO of 3-bit codes. Pointers carry one extra
// MSB so that full and empty are distinguished without a separate counter.
module prdec_fifo
    import prdec_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [CODE_W-1:0] i_din,
    output logic [CODE_W-1:0] o_dout,
    output logic              o_full,
    output logic              o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [CODE_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_dout  = r_mem[r_rptr[AW-1:0]];

    // Advance read/write pointers; guarded so misuse cannot corrupt state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= {PW{1'b0}};
            r_rptr <= {PW{1'b0}};
        end else begin
            if (i_push && !o_full) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (i_pop && !o_empty) begin
                r_rptr <= r_rptr + PW'(1);
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[r_wptr[AW-1:0]] <= i_din;
        end
    end

endmodule

// File: rtl/prdec_seq.sv
// prdec_seq: sequential 2-to-4 priority-code decoder. Codes {Y,A,B} are
// queued through a valid/ready handshake and each is replayed as a one-hot
// pulse on D0..D3 for HOLD cycles, back-to-back with no gap.
// Optional per-line hit counters are built when PRDEC_HIT_CNT_EN is defined;
// otherwise hit_cnt is tied to zero.
module prdec_seq
    import prdec_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HOLD  = 3,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 A,
    input  logic                 B,
    input  logic                 Y,
    output logic                 D0,
    output logic                 D1,
    output logic                 D2,
    output logic                 D3,
    output logic                 busy,
    output logic [4*CNT_W-1:0]   hit_cnt
);
    localparam int                HOLD_W    = $clog2(HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD - 1);

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [CODE_W-1:0]    w_head;

    state_e               r_state;
    logic [HOLD_W-1:0]    r_hold;
    logic [NUM_LINES-1:0] r_d;
    logic                 r_busy;

    // Ready reflects only FIFO state (no bypass) and is held low in reset.
    assign in_ready = rst_n && !w_full;
    assign w_push   = in_valid && in_ready;
    // A new slot starts when idle or when the current slot's last cycle ends.
    assign w_pop    = !w_empty &&
                      ((r_state == IDLE) || (r_hold == {HOLD_W{1'b0}}));

    prdec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   ({Y, A, B}),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Slot sequencer: loads a decoded code, holds it HOLD cycles, chains or idles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_hold  <= {HOLD_W{1'b0}};
            r_d     <= {NUM_LINES{1'b0}};
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state <= DRIVE;
                        r_hold  <= HOLD_LOAD;
                        r_d     <= decode_code(w_head);
                        r_busy  <= 1'b1;
                    end else begin
                        r_d     <= {NUM_LINES{1'b0}};
                        r_busy  <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (r_hold != {HOLD_W{1'b0}}) begin
                        r_hold  <= r_hold - HOLD_W'(1);
                    end else if (w_pop) begin
                        r_hold  <= HOLD_LOAD;
                        r_d     <= decode_code(w_head);
                    end else begin
                        r_state <= IDLE;
                        r_d     <= {NUM_LINES{1'b0}};
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_hold  <= {HOLD_W{1'b0}};
                    r_d     <= {NUM_LINES{1'b0}};
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign D0   = r_d[LINE_0];
    assign D1   = r_d[LINE_1];
    assign D2   = r_d[LINE_2];
    assign D3   = r_d[LINE_3];
    assign busy = r_busy;

`ifdef PRDEC_HIT_CNT_EN
    logic [CNT_W-1:0] r_hit [NUM_LINES];

    // Saturating per-line hit counters, bumped when a Y=1 code starts its slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                r_hit[i] <= {CNT_W{1'b0}};
            end
        end else if (w_pop && w_head[CODE_Y]) begin
            if (r_hit[{w_head[CODE_A], w_head[CODE_B]}] != {CNT_W{1'b1}}) begin
                r_hit[{w_head[CODE_A], w_head[CODE_B]}] <=
                    r_hit[{w_head[CODE_A], w_head[CODE_B]}] + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_hit
        assign hit_cnt[g*CNT_W +: CNT_W] = r_hit[g];
    end
`else
    assign hit_cnt = {(4*CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_prdec_seq.sv
// tb_prdec_seq: scoreboard bench for prdec_seq. Accepted codes are queued
// by a cycle-level reference model and compared against D/busy/in_ready/
// hit_cnt after every rising edge (sampled on the falling edge).
module tb_prdec_seq;
    localparam int DEPTH = 4;
    localparam int HOLD  = 3;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n    = 1'b0;
    logic               in_valid = 1'b0;
    logic               A        = 1'b0;
    logic               B        = 1'b0;
    logic               Y        = 1'b0;
    logic               in_ready;
    logic               D0, D1, D2, D3;
    logic               busy;
    logic [4*CNT_W-1:0] hit_cnt;

    prdec_seq #(.DEPTH(DEPTH), .HOLD(HOLD), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Y        (Y),
        .D0       (D0),
        .D1       (D1),
        .D2       (D2),
        .D3       (D3),
        .busy     (busy),
        .hit_cnt  (hit_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [2:0]       m_q [$];
    logic [3:0]       m_d     = 4'b0000;
    logic             m_busy  = 1'b0;
    int               m_hold  = 0;
    logic [CNT_W-1:0] m_hit [4];
    logic             m_pushed = 1'b0;
    logic             rdy_drop = 1'b0;
    logic             saw_stall = 1'b0;

    function automatic logic [3:0] dec(input logic [2:0] c);
        logic [3:0] v;
        v = 4'b0000;
        if (c[2]) v[c[1:0]] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: step the model with the inputs seen at the rising edge, then compare.
    task automatic cycle();
        logic [2:0]         c;
        logic               pre_rdy;
        logic [4*CNT_W-1:0] exp_hit;
        @(negedge clk);
        m_pushed = 1'b0;
        if (!rst_n) begin
            m_q.delete();
            m_d    = 4'b0000;
            m_busy = 1'b0;
            m_hold = 0;
            for (int i = 0; i < 4; i++) m_hit[i] = {CNT_W{1'b0}};
        end else begin
            pre_rdy = (m_q.size() < DEPTH);
            if (m_q.size() > 0 && (!m_busy || m_hold == 0)) begin
                c      = m_q.pop_front();
                m_d    = dec(c);
                m_busy = 1'b1;
                m_hold = HOLD - 1;
`ifdef PRDEC_HIT_CNT_EN
                if (c[2] && m_hit[c[1:0]] != {CNT_W{1'b1}})
                    m_hit[c[1:0]] = m_hit[c[1:0]] + 1'b1;
`endif
            end else if (m_busy && m_hold > 0) begin
                m_hold = m_hold - 1;
            end else begin
                m_busy = 1'b0;
                m_d    = 4'b0000;
            end
            if (in_valid && pre_rdy) begin
                m_q.push_back({Y, A, B});
                m_pushed = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) exp_hit[i*CNT_W +: CNT_W] = m_hit[i];
        check("dline", {28'd0, D3, D2, D1, D0}, {28'd0, m_d});
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("ready", {31'd0, in_ready}, {31'd0, (rst_n && (m_q.size() < DEPTH))});
        check("hitcnt", {24'd0, hit_cnt}, {24'd0, exp_hit});
        if (rst_n && !in_ready) rdy_drop = 1'b1;
        if (rst_n && in_valid && !in_ready) saw_stall = 1'b1;
    endtask

    // Offer a code and hold it until accepted (bounded); leaves in_valid high.
    task automatic send(input logic [2:0] c);
        {Y, A, B} = c;
        in_valid  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (m_pushed) break;
        end
        check("send_accept", {31'd0, m_pushed}, 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin : stim
        int         d2_cnt;
        logic [7:0] exp_sat;
        for (int i = 0; i < 4; i++) m_hit[i] = {CNT_W{1'b0}};

        // Reset
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Single code Y=1,A=1,B=0 -> D2 for HOLD cycles, starting one edge later
        send(3'b110);
        in_valid = 1'b0;
        cycle();
        check("t1_first", {28'd0, D3, D2, D1, D0}, 32'h4);
        d2_cnt = 1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (D2 === 1'b1) d2_cnt++;
        end
        check("t1_d2_len", d2_cnt, HOLD);
        check("t1_busy_end", {31'd0, busy}, 32'd0);

        // Four codes back-to-back; ready must stay high
        rdy_drop = 1'b0;
        send(3'b100); send(3'b101); send(3'b110); send(3'b111);
        idle(15);
        check("t2_ready_kept", {31'd0, rdy_drop}, 32'd0);

        // Eight codes without pause -> FIFO fills and source stalls
        rdy_drop  = 1'b0;
        saw_stall = 1'b0;
        send(3'b111); send(3'b100); send(3'b110); send(3'b101);
        send(3'b100); send(3'b111); send(3'b011); send(3'b110);
        idle(30);
        check("t3_ready_drop", {31'd0, rdy_drop}, 32'd1);
        check("t3_stall_seen", {31'd0, saw_stall}, 32'd1);

        // Y=0 slot between two line codes
        send(3'b101); send(3'b011); send(3'b110);
        idle(15);

        // Reset mid-DRIVE with two codes queued
        send(3'b100); send(3'b111); send(3'b110);
        in_valid = 1'b0;
        cycle();
        check("t5_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        cycle();
        check("t5_d_in_rst", {28'd0, D3, D2, D1, D0}, 32'd0);
        rst_n = 1'b1;
        cycle();
        check("t5_ready_post", {31'd0, in_ready}, 32'd1);
        idle(10);

        // Saturation of line-3 counter
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        repeat (5) send(3'b111);
        idle(20);
`ifdef PRDEC_HIT_CNT_EN
        exp_sat = 8'hC0;
`else
        exp_sat = 8'h00;
`endif
        check("t6_hit_sat", {24'd0, hit_cnt}, {24'd0, exp_sat});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
